// File: rtl/sram_dp_pkg.sv
// Shared widths, payload types and conflict helper for the dual-port SRAM requester.
package sram_dp_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  // Two eligible requests to the same word collide unless both are reads.
  function automatic logic is_conflict(input logic elig1, input logic elig2,
                                       input logic we1, input logic we2,
                                       input logic same_addr);
    return elig1 && elig2 && same_addr && (we1 || we2);
  endfunction

endpackage

// File: rtl/sram_dp_port.sv
// One requester port: fire/pin drive, response-valid register and hold.
// SRAM_DP_FWD_EN adds a write-data forwarding register on the read-response path.
module sram_dp_port #(
  parameter int unsigned ADDR_W = sram_dp_pkg::ADDR_W,
  parameter int unsigned DATA_W = sram_dp_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready_c,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              arb_block,
`ifdef SRAM_DP_FWD_EN
  input  logic              fwd_hit,
  input  logic [DATA_W-1:0] fwd_wdata,
`endif
  output logic              hold_c,
  output logic              rsp_valid_c,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata_c,
  output logic              csb_c,
  output logic              web_c,
  output logic              oeb_c,
  output logic [ADDR_W-1:0] a_c,
  output logic [DATA_W-1:0] i_c,
  input  logic [DATA_W-1:0] o_data
);

  logic rsp_valid_q, rsp_valid_d;
  logic fire;

  // Response is masked during reset so a pending read never surfaces.
  always_comb begin
    rsp_valid_c = rsp_valid_q && !reset;
    hold_c      = rsp_valid_c && !rsp_ready;
    req_ready_c = !reset && !hold_c && !arb_block;
    fire        = req_valid && req_ready_c;
    csb_c       = 1'b1;
    web_c       = 1'b1;
    oeb_c       = 1'b1;
    a_c         = '0;
    i_c         = '0;
    rsp_valid_d = rsp_valid_q;
    if (fire) begin
      csb_c = 1'b0;
      web_c = ~req_we;
      oeb_c = req_we;
      a_c   = req_addr;
      i_c   = req_wdata;
    end
    if (rsp_valid_c && rsp_ready) rsp_valid_d = 1'b0;
    if (fire && !req_we)          rsp_valid_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) rsp_valid_q <= 1'b0;
    else       rsp_valid_q <= rsp_valid_d;
  end

`ifdef SRAM_DP_FWD_EN
  logic              fwd_sel_q, fwd_sel_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  // Latch the colliding write data alongside each accepted read.
  always_comb begin
    fwd_sel_d  = fwd_sel_q;
    fwd_data_d = fwd_data_q;
    if (fire && !req_we) begin
      fwd_sel_d  = fwd_hit;
      fwd_data_d = fwd_wdata;
    end
    rsp_rdata_c = fwd_sel_q ? fwd_data_q : o_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_sel_q  <= fwd_sel_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`else
  assign rsp_rdata_c = o_data;
`endif

endmodule

// File: rtl/sram_dp_requester.sv
// Dual-port SRAM requester: two valid/ready ports with same-address conflict arbitration.
// Build option SRAM_DP_FWD_EN forwards write data to a colliding read instead of stalling.
module sram_dp_requester #(
  parameter int unsigned ADDR_W = sram_dp_pkg::ADDR_W,
  parameter int unsigned DATA_W = sram_dp_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req2_valid,
  output logic              req2_ready,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp2_valid,
  input  logic              rsp2_ready,
  output logic [DATA_W-1:0] rsp2_rdata,
  output logic              CSB1,
  output logic              WEB1,
  output logic              OEB1,
  output logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] I1,
  input  logic [DATA_W-1:0] O1,
  output logic              CSB2,
  output logic              WEB2,
  output logic              OEB2,
  output logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] I2,
  input  logic [DATA_W-1:0] O2
);
  import sram_dp_pkg::*;

  logic prio_q, prio_d;
  logic hold1, hold2;
  logic conflict, arb, block1, block2;
`ifdef SRAM_DP_FWD_EN
  logic fwd_hit1, fwd_hit2;
`endif

  // A port stalled on its own response is excluded before arbitration.
  always_comb begin
    conflict = is_conflict(req1_valid && !hold1, req2_valid && !hold2,
                           req1_we, req2_we, req1_addr == req2_addr);
`ifdef SRAM_DP_FWD_EN
    arb      = conflict && req1_we && req2_we;
    fwd_hit1 = conflict && !req1_we;
    fwd_hit2 = conflict && !req2_we;
`else
    arb      = conflict;
`endif
    block1 = arb && prio_q;
    block2 = arb && !prio_q;
    prio_d = prio_q ^ arb;
  end

  always_ff @(posedge clock) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  sram_dp_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req1_valid),
    .req_ready_c (req1_ready),
    .req_we      (req1_we),
    .req_addr    (req1_addr),
    .req_wdata   (req1_wdata),
    .arb_block   (block1),
`ifdef SRAM_DP_FWD_EN
    .fwd_hit     (fwd_hit1),
    .fwd_wdata   (req2_wdata),
`endif
    .hold_c      (hold1),
    .rsp_valid_c (rsp1_valid),
    .rsp_ready   (rsp1_ready),
    .rsp_rdata_c (rsp1_rdata),
    .csb_c       (CSB1),
    .web_c       (WEB1),
    .oeb_c       (OEB1),
    .a_c         (A1),
    .i_c         (I1),
    .o_data      (O1)
  );

  sram_dp_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port2 (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req2_valid),
    .req_ready_c (req2_ready),
    .req_we      (req2_we),
    .req_addr    (req2_addr),
    .req_wdata   (req2_wdata),
    .arb_block   (block2),
`ifdef SRAM_DP_FWD_EN
    .fwd_hit     (fwd_hit2),
    .fwd_wdata   (req1_wdata),
`endif
    .hold_c      (hold2),
    .rsp_valid_c (rsp2_valid),
    .rsp_ready   (rsp2_ready),
    .rsp_rdata_c (rsp2_rdata),
    .csb_c       (CSB2),
    .web_c       (WEB2),
    .oeb_c       (OEB2),
    .a_c         (A2),
    .i_c         (I2),
    .o_data      (O2)
  );

endmodule

// File: tb/tb_sram_dp_requester.sv
// Directed self-checking bench for sram_dp_requester with a behavioural dual-port SRAM.
module tb_sram_dp_requester;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic reset;
  logic req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic req2_valid, req2_ready, req2_we;
  logic [AW-1:0] req2_addr;
  logic [DW-1:0] req2_wdata;
  logic rsp1_valid, rsp1_ready, rsp2_valid, rsp2_ready;
  logic [DW-1:0] rsp1_rdata, rsp2_rdata;
  logic CSB1, WEB1, OEB1, CSB2, WEB2, OEB2;
  logic [AW-1:0] A1, A2;
  logic [DW-1:0] I1, I2, O1, O2;
  logic [DW-1:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;
  int cnt1, cnt2;

  always #5 clock = ~clock;

  sram_dp_requester #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_we(req2_we),
    .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .rsp2_valid(rsp2_valid), .rsp2_ready(rsp2_ready), .rsp2_rdata(rsp2_rdata),
    .CSB1(CSB1), .WEB1(WEB1), .OEB1(OEB1), .A1(A1), .I1(I1), .O1(O1),
    .CSB2(CSB2), .WEB2(WEB2), .OEB2(OEB2), .A2(A2), .I2(I2), .O2(O2)
  );

  // Behavioural SRAM; preloaded with 0x1000_0000+addr whenever reset is high.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      O1 <= '0;
      O2 <= '0;
    end else begin
      if (!CSB1) begin
        if (!WEB1) mem[A1] <= I1;
        else if (!OEB1) O1 <= mem[A1];
      end
      if (!CSB2) begin
        if (!WEB2) mem[A2] <= I2;
        else if (!OEB2) O2 <= mem[A2];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    req2_valid = 0; req2_we = 0; req2_addr = '0; req2_wdata = '0;
    rsp1_ready = 1; rsp2_ready = 1;
  endtask

  task automatic drive1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic drive2(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req2_valid = 1; req2_we = we; req2_addr = a; req2_wdata = d;
  endtask

  initial begin
    reset = 1;
    idle();
    // Reset state: pins idle and ready low even with a request pending
    @(negedge clock);
    drive1(1, 5'd1, 32'h1234_5678);
    #1;
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_csb1", 32'(CSB1), 1);
    chk("rst_web1", 32'(WEB1), 1);
    chk("rst_oeb1", 32'(OEB1), 1);
    chk("rst_a1", 32'(A1), 0);
    chk("rst_i1", I1, 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp2_valid", 32'(rsp2_valid), 0);
    @(negedge clock);
    reset = 0;
    idle();

    // Write via port 1, read back via port 2
    @(negedge clock);
    drive1(1, 5'd3, 32'hDEAD_BEEF);
    #1;
    chk("wr_ready1", 32'(req1_ready), 1);
    chk("wr_csb1", 32'(CSB1), 0);
    chk("wr_web1", 32'(WEB1), 0);
    chk("wr_oeb1", 32'(OEB1), 1);
    chk("wr_a1", 32'(A1), 3);
    chk("wr_i1", I1, 32'hDEAD_BEEF);
    @(negedge clock);
    idle();
    drive2(0, 5'd3, '0);
    #1;
    chk("rd_ready2", 32'(req2_ready), 1);
    chk("rd_csb2", 32'(CSB2), 0);
    chk("rd_web2", 32'(WEB2), 1);
    chk("rd_oeb2", 32'(OEB2), 0);
    chk("wr_no_rsp1", 32'(rsp1_valid), 0);
    @(negedge clock);
    idle();
    #1;
    chk("rd_rsp2_valid", 32'(rsp2_valid), 1);
    chk("rd_rsp2_rdata", rsp2_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp1_quiet", 32'(rsp1_valid), 0);
    @(negedge clock);
    #1;
    chk("rd_rsp2_done", 32'(rsp2_valid), 0);

    // Write-write conflict, prio=0: port 1 first then port 2
    @(negedge clock);
    drive1(1, 5'd7, 32'h1111_1111);
    drive2(1, 5'd7, 32'h2222_2222);
    #1;
    chk("ww_ready1", 32'(req1_ready), 1);
    chk("ww_ready2", 32'(req2_ready), 0);
    chk("ww_csb2", 32'(CSB2), 1);
    chk("ww_prio0", 32'(dut.prio_q), 0);
    @(negedge clock);
    req1_valid = 0;
    #1;
    chk("ww_ready2_next", 32'(req2_ready), 1);
    chk("ww_i2", I2, 32'h2222_2222);
    chk("ww_prio1", 32'(dut.prio_q), 1);
    @(negedge clock);
    idle();
    drive1(0, 5'd7, '0);
    #1;
    chk("ww_rd_ready1", 32'(req1_ready), 1);
    @(negedge clock);
    idle();
    #1;
    chk("ww_rd_valid", 32'(rsp1_valid), 1);
    chk("ww_rd_rdata", rsp1_rdata, 32'h2222_2222);

    // Response hold on port 1 for 4 cycles; port 2 unaffected
    @(negedge clock);
    idle();
    rsp1_ready = 0;
    drive1(0, 5'd5, '0);
    #1;
    chk("hold_fire_ready1", 32'(req1_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive1(0, 5'd10, '0);
      if (k == 0) drive2(0, 5'd6, '0);
      else req2_valid = 0;
      #1;
      chk("hold_ready1", 32'(req1_ready), 0);
      chk("hold_csb1", 32'(CSB1), 1);
      chk("hold_valid1", 32'(rsp1_valid), 1);
      chk("hold_rdata1", rsp1_rdata, 32'h1000_0005);
      if (k == 0) chk("hold_p2_ready", 32'(req2_ready), 1);
      if (k == 1) begin
        chk("hold_p2_valid", 32'(rsp2_valid), 1);
        chk("hold_p2_rdata", rsp2_rdata, 32'h1000_0006);
      end
    end
    @(negedge clock);
    rsp1_ready = 1;
    #1;
    chk("hold_release_ready1", 32'(req1_ready), 1);
    chk("hold_release_valid1", 32'(rsp1_valid), 1);
    @(negedge clock);
    idle();
    #1;
    chk("hold_next_valid1", 32'(rsp1_valid), 1);
    chk("hold_next_rdata1", rsp1_rdata, 32'h1000_000A);
    @(negedge clock);
    #1;
    chk("hold_drained1", 32'(rsp1_valid), 0);

    // Read/write conflict on addr 9 (prio is 1 here)
    @(negedge clock);
    drive1(1, 5'd9, 32'hA5A5_A5A5);
    drive2(0, 5'd9, '0);
    #1;
`ifdef SRAM_DP_FWD_EN
    chk("rw_ready1", 32'(req1_ready), 1);
    chk("rw_ready2", 32'(req2_ready), 1);
    @(negedge clock);
    idle();
    #1;
    chk("rw_rsp2_valid", 32'(rsp2_valid), 1);
    chk("rw_rsp2_rdata", rsp2_rdata, 32'hA5A5_A5A5);
    chk("rw_prio", 32'(dut.prio_q), 1);
`else
    chk("rw_ready1", 32'(req1_ready), 0);
    chk("rw_ready2", 32'(req2_ready), 1);
    chk("rw_csb1", 32'(CSB1), 1);
    @(negedge clock);
    req2_valid = 0;
    #1;
    chk("rw_ready1_next", 32'(req1_ready), 1);
    chk("rw_rsp2_valid", 32'(rsp2_valid), 1);
    chk("rw_rsp2_rdata", rsp2_rdata, 32'h1000_0009);
    chk("rw_prio", 32'(dut.prio_q), 0);
    @(negedge clock);
    idle();
`endif
    @(negedge clock);
    idle();
    drive2(0, 5'd9, '0);
    @(negedge clock);
    idle();
    #1;
    chk("rw_readback", rsp2_rdata, 32'hA5A5_A5A5);

    // Reset while port 1 holds a response and port 2 has just fired a read
    @(negedge clock);
    idle();
    rsp1_ready = 0;
    drive1(0, 5'd3, '0);
    @(negedge clock);
    req1_valid = 0;
    drive2(0, 5'd4, '0);
    #1;
    chk("pre_rst_valid1", 32'(rsp1_valid), 1);
    chk("pre_rst_ready1", 32'(req1_ready), 0);
    @(negedge clock);
    reset = 1;
    req2_valid = 0;
    #1;
    chk("in_rst_valid1", 32'(rsp1_valid), 0);
    chk("in_rst_valid2", 32'(rsp2_valid), 0);
    chk("in_rst_ready2", 32'(req2_ready), 0);
    @(negedge clock);
    reset = 0;
    #1;
    chk("post_rst_valid1", 32'(rsp1_valid), 0);
    chk("post_rst_valid2", 32'(rsp2_valid), 0);
    chk("post_rst_prio", 32'(dut.prio_q), 0);
    chk("post_rst_csb1", 32'(CSB1), 1);
    chk("post_rst_csb2", 32'(CSB2), 1);
    chk("post_rst_ready1", 32'(req1_ready), 1);
    @(negedge clock);
    rsp1_ready = 1;
    #1;
    chk("post_rst_stale1", 32'(rsp1_valid), 0);

    // Streaming reads on both ports: 32 responses each in 33 cycles
    idle();
    cnt1 = 0;
    cnt2 = 0;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clock);
      if (k < 32) begin
        drive1(0, AW'(k), '0);
        drive2(0, AW'((k + 16) % 32), '0);
      end else begin
        req1_valid = 0;
        req2_valid = 0;
      end
      #1;
      if (k < 32) begin
        chk("strm_ready1", 32'(req1_ready), 1);
        chk("strm_ready2", 32'(req2_ready), 1);
      end
      chk("strm_valid1", 32'(rsp1_valid), (k >= 1) ? 1 : 0);
      chk("strm_valid2", 32'(rsp2_valid), (k >= 1) ? 1 : 0);
      if (rsp1_valid) begin
        cnt1++;
        chk("strm_rdata1", rsp1_rdata, 32'h1000_0000 + 32'(k - 1));
      end
      if (rsp2_valid) begin
        cnt2++;
        chk("strm_rdata2", rsp2_rdata, 32'h1000_0000 + 32'((k + 15) % 32));
      end
    end
    @(negedge clock);
    #1;
    chk("strm_cnt1", 32'(cnt1), 32);
    chk("strm_cnt2", 32'(cnt2), 32);
    chk("strm_end_valid1", 32'(rsp1_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_dp_requester.md
SRAM_DP_REQUESTER -- requirements
Module: sram_dp_requester

Interface
REQ-001 SHALL have parameters ADDR_W, default 5, SRAM word-address width; DATA_W, default 32, SRAM word width.
REQ-002 SHALL have ports: clock  in  1  single clock; also the SRAM macro clock, so CE1/CE2 are tied to clock externally.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports, per port p in {1,2}: reqp_valid in 1; reqp_ready out 1; reqp_we in 1 (1=write, 0=read); reqp_addr in ADDR_W; reqp_wdata in DATA_W.
REQ-005 SHALL have ports, per port p: rspp_valid out 1; rspp_ready in 1; rspp_rdata out DATA_W (read data only).
REQ-006 SHALL have ports, per port p, driving the dual-port SRAM: CSBp out 1; WEBp out 1; OEBp out 1 (all active-low); Ap out ADDR_W; Ip out DATA_W; Op in DATA_W.

Function
REQ-007 SHALL accept a request on port p at a rising edge when reqp_valid && reqp_ready (the "fire" condition).
REQ-008 SHALL drive the SRAM pins combinationally in the fire cycle: CSBp=0; WEBp=~we; OEBp=we; Ap=addr; Ip=wdata. When port p does not fire, it SHALL drive CSBp=WEBp=OEBp=1 and Ap=0, Ip=0.
REQ-009 For a read fired at edge N, SHALL assert rspp_valid from cycle N+1 and hold it until rspp_valid && rspp_ready; rspp_rdata SHALL equal Op while valid.
REQ-010 Writes SHALL produce no response.
REQ-011 reqp_ready SHALL be 0 while rspp_valid && !rspp_ready. This keeps Op stable, because the SRAM output changes only on a read.
REQ-012 With rspp_ready held at 1, back-to-back reads SHALL fire every cycle at full throughput.
REQ-013 Conflict definition: both ports valid, same address, and at least one is a write.
REQ-014 On a conflict, exactly one port SHALL be ready: the port selected by the 1-bit priority register prio (0 = port 1, 1 = port 2).
REQ-015 prio SHALL toggle after each conflict resolution, giving round-robin between ports.
REQ-016 prio SHALL NOT change when there is no conflict.
REQ-017 On a non-conflicting simultaneous access, both ports SHALL fire in the same cycle.
REQ-018 A read-port response hold (REQ-011) SHALL be evaluated before conflict arbitration. A port blocked by its own response hold does not participate in the conflict, and prio does not toggle.
REQ-019 Write-write conflicts SHALL always serialize, winner first; the final memory contents equal the loser's data.

Reset
REQ-020 While reset=1 at an edge, the block SHALL clear rsp1_valid, rsp2_valid and prio.
REQ-021 While reset=1, reqp_ready=0 and the SRAM pins are at their idle values (REQ-008).
REQ-022 A read fired in the cycle before reset asserts SHALL produce no response; reset mid-hold SHALL discard the pending response.
REQ-023 reqp_ready SHALL be allowed to return to 1 in the first cycle after reset deasserts.
REQ-024 The reset value of every output SHALL be as follows: ready=0, rsp_valid=0, rsp_rdata=Op pass-through, CSB/WEB/OEB=1, A=0, I=0.

Configuration
REQ-025 Macro SRAM_DP_FWD_EN SHALL control read-write forwarding.
REQ-026 When SRAM_DP_FWD_EN is defined, a read/write conflict SHALL NOT stall. Both ports fire, the SRAM read is issued, and the read response returns the write data, captured in a DATA_W forwarding register selected on the response mux. prio does not toggle.
REQ-027 When SRAM_DP_FWD_EN is undefined, a read/write conflict SHALL be arbitrated per REQ-014, and the forwarding register and mux SHALL not exist.
REQ-028 Write-write behaviour SHALL be identical with and without SRAM_DP_FWD_EN.

Structure
REQ-029 Package sram_dp_pkg SHALL hold ADDR_W/DATA_W defaults, DEPTH=32, and the typedefs req_t {we, addr, wdata} and rsp_t {rdata}.
REQ-030 Sub-module sram_dp_port SHALL be instantiated twice. Each instance handles one port's fire logic, pin drive, response-valid register, hold, and (with SRAM_DP_FWD_EN) the forwarding register.
REQ-031 Conflict detection and prio SHALL be in the top level.

Verification
REQ-032 Write 0xDEADBEEF to addr 3 via port 1, then read addr 3 via port 2 -> rsp2_valid one cycle after the read fires, rdata=0xDEADBEEF.
REQ-033 Both ports write addr 7 in the same cycle (0x11111111 on port 1, 0x22222222 on port 2) with prio=0 -> port 1 fires first, port 2 fires the next cycle, prio=1 afterwards, a read of 7 returns 0x22222222.
REQ-034 Port 1 reads addr 5 with rsp1_ready=0 for 4 cycles -> req1_ready=0 and rsp1_rdata stable for those cycles; meanwhile port 2 reads addr 6 unaffected.
REQ-035 Port 1 writes 0xA5A5A5A5 to addr 9 while port 2 reads addr 9 in the same cycle -> with SRAM_DP_FWD_EN: both fire and rsp2_rdata=0xA5A5A5A5; without it: prio winner fires first and port 2 reads either the old value or 0xA5A5A5A5 according to order.
REQ-036 Assert reset for 1 cycle while rsp1_valid=1 -> rsp1_valid=0, prio=0, all CSB=1 in the following cycle, and no stale response appears.
REQ-037 Both ports stream 32 reads to distinct addresses with rsp_ready=1 -> 32 responses per port in 33 cycles, no stalls.
